// File: rtl/core_config_pkg.sv
// Core-wide configuration constants shared by the ALU blocks.
package core_config_pkg;
  localparam int unsigned XLEN = 32;
endpackage

// File: rtl/shift_arbiter.sv
// Round-robin arbiter that shares one iterative shifter between NUM_REQ requesters
// and returns each result tagged with the owning requester index.
module shift_arbiter #(
  parameter int unsigned XLEN    = core_config_pkg::XLEN,
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDW     = $clog2(NUM_REQ),
  parameter int unsigned SAW     = $clog2(XLEN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*XLEN-1:0] req_data,
  input  logic [NUM_REQ*SAW-1:0]  req_amount,
  input  logic [NUM_REQ-1:0]      req_left,
  input  logic [NUM_REQ-1:0]      req_arith,
  input  logic                    flush,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [XLEN-1:0]         rsp_data,
  output logic [IDW-1:0]          rsp_id,
  output logic                    busy,
  output logic                    sh_start,
  output logic [XLEN-1:0]         sh_data,
  output logic [SAW-1:0]          sh_amount,
  output logic                    sh_left,
  output logic                    sh_arith,
  input  logic                    sh_done,
  input  logic [XLEN-1:0]         sh_result
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic            r_drop;
  logic            w_drop_nxt;
  logic [IDW-1:0]  r_rr_ptr;
  logic [IDW-1:0]  w_rr_nxt;
  logic [IDW-1:0]  w_gnt_idx;
  logic            w_gnt_found;
  logic            w_grant;
  logic            w_capture;
  logic [XLEN-1:0] w_gnt_data;
  logic [SAW-1:0]  w_gnt_amount;
  logic            w_gnt_left;
  logic            w_gnt_arith;

  logic            r_rsp_valid;
  logic [XLEN-1:0] r_rsp_data;
  logic [IDW-1:0]  r_rsp_id;
  logic            r_busy;
  logic            r_sh_start;
  logic [XLEN-1:0] r_sh_data;
  logic [SAW-1:0]  r_sh_amount;
  logic            r_sh_left;
  logic            r_sh_arith;

  // First valid requester at or after the round-robin pointer, with wrap-around.
  always_comb begin
    logic [IDW-1:0] cand;
    cand        = '0;
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IDW'((32'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_gnt_found && req_valid[cand]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    w_gnt_data   = '0;
    w_gnt_amount = '0;
    w_gnt_left   = 1'b0;
    w_gnt_arith  = 1'b0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (w_gnt_idx == IDW'(j)) begin
        w_gnt_data   = req_data[j*XLEN +: XLEN];
        w_gnt_amount = req_amount[j*SAW +: SAW];
        w_gnt_left   = req_left[j];
        w_gnt_arith  = req_arith[j];
      end
    end
  end

  assign w_grant   = !rst && (r_state == S_IDLE) && !flush && w_gnt_found;
  assign w_rr_nxt  = (w_gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : w_gnt_idx + IDW'(1);
  assign req_ready = w_grant ? (NUM_REQ'(1) << w_gnt_idx) : '0;

  // Next-state logic; a flush during the shifter run only marks the result for dropping.
  always_comb begin
    w_state_nxt = r_state;
    w_drop_nxt  = r_drop;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        w_state_nxt = S_WAIT;
        if (flush) w_drop_nxt = 1'b1;
      end
      S_WAIT: begin
        if (sh_done) begin
          if (r_drop || flush) begin
            w_drop_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
          end else begin
            w_capture   = 1'b1;
            w_state_nxt = S_RESP;
          end
        end else if (flush) begin
          w_drop_nxt = 1'b1;
        end
      end
      S_RESP: begin
        if (flush || rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_drop      <= 1'b0;
      r_rr_ptr    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
      r_busy      <= 1'b0;
      r_sh_start  <= 1'b0;
      r_sh_data   <= '0;
      r_sh_amount <= '0;
      r_sh_left   <= 1'b0;
      r_sh_arith  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_drop      <= w_drop_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_sh_start  <= (w_state_nxt == S_ISSUE);
      r_rsp_valid <= (w_state_nxt == S_RESP);
      if (w_grant) begin
        r_rr_ptr    <= w_rr_nxt;
        r_rsp_id    <= w_gnt_idx;
        r_sh_data   <= w_gnt_data;
        r_sh_amount <= w_gnt_amount;
        r_sh_left   <= w_gnt_left;
        r_sh_arith  <= w_gnt_arith;
      end
      if (w_capture) r_rsp_data <= sh_result;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;
  assign busy      = r_busy;
  assign sh_start  = r_sh_start;
  assign sh_data   = r_sh_data;
  assign sh_amount = r_sh_amount;
  assign sh_left   = r_sh_left;
  assign sh_arith  = r_sh_arith;

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: behavioural shifter, transaction-level reference model,
// directed latency/flush/reset scenarios and a randomized soak.
module tb_shift_arbiter;
  localparam int XLEN = 32;
  localparam int NR   = 2;
  localparam int SAW  = 5;
  localparam int MSPC = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid, req_ready, req_left, req_arith;
  logic [NR*XLEN-1:0] req_data;
  logic [NR*SAW-1:0]  req_amount;
  logic            flush, rsp_valid, rsp_ready;
  logic [XLEN-1:0] rsp_data;
  logic [0:0]      rsp_id;
  logic            busy, sh_start, sh_left, sh_arith, sh_done;
  logic [XLEN-1:0] sh_data, sh_result;
  logic [SAW-1:0]  sh_amount;

  shift_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_amount(req_amount), .req_left(req_left),
    .req_arith(req_arith), .flush(flush), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy),
    .sh_start(sh_start), .sh_data(sh_data), .sh_amount(sh_amount),
    .sh_left(sh_left), .sh_arith(sh_arith), .sh_done(sh_done),
    .sh_result(sh_result)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] shift_ref(input logic [XLEN-1:0] d, input int a,
                                                input logic l, input logic ar);
    logic signed [XLEN-1:0] sd;
    sd = d;
    if (l) return d << a;
    if (ar) return sd >>> a;
    return d >> a;
  endfunction

  // Iterative shifter: done rises 2+ceil(amount/3) cycles after start, held until next start.
  logic [XLEN-1:0] s_res;
  logic            s_done;
  int              s_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_done <= 1'b0; s_cnt <= 0; s_res <= '0;
    end else if (sh_start) begin
      s_done <= 1'b0;
      s_cnt  <= (int'(sh_amount) + MSPC - 1) / MSPC + 1;
      s_res  <= shift_ref(sh_data, int'(sh_amount), sh_left, sh_arith);
    end else if (s_cnt > 0) begin
      s_cnt <= s_cnt - 1;
      if (s_cnt == 1) s_done <= 1'b1;
    end
  end
  assign sh_done   = s_done;
  assign sh_result = s_res;

  // Transaction-level reference: one op in flight, tracked by age and response/drop flags.
  logic            m_act, m_resp, m_drop;
  int              m_t, m_rr, m_id, g, c;
  logic [XLEN-1:0] m_exp, m_rsp_data, m_sh_data;
  logic [SAW-1:0]  m_sh_amt;
  logic            m_sh_left, m_sh_arith;
  logic [NR-1:0]   exp_rdy;

  always @(negedge clk) begin
    g = -1;
    exp_rdy = '0;
    if (rst) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_sh_start", sh_start, 0);
      m_act = 0; m_resp = 0; m_drop = 0; m_t = 0; m_rr = 0; m_id = 0;
      m_exp = '0; m_rsp_data = '0; m_sh_data = '0; m_sh_amt = '0;
      m_sh_left = 0; m_sh_arith = 0;
    end else begin
      if (!m_act && !flush)
        for (int k = 0; k < NR; k++) begin
          c = (m_rr + k) % NR;
          if (g < 0 && req_valid[c]) g = c;
        end
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", req_ready, exp_rdy);
      chk("busy", busy, m_act);
      chk("sh_start", sh_start, m_act && !m_resp && m_t == 1);
      chk("rsp_valid", rsp_valid, m_resp);
      chk("rsp_data", rsp_data, m_rsp_data);
      chk("rsp_id", rsp_id, m_id);
      chk("sh_data", sh_data, m_sh_data);
      chk("sh_amount", sh_amount, m_sh_amt);
      chk("sh_left", sh_left, m_sh_left);
      chk("sh_arith", sh_arith, m_sh_arith);
      if (g >= 0) begin
        m_act = 1; m_t = 1; m_drop = 0; m_id = g; m_rr = (g + 1) % NR;
        m_sh_data  = req_data[g*XLEN +: XLEN];
        m_sh_amt   = req_amount[g*SAW +: SAW];
        m_sh_left  = req_left[g];
        m_sh_arith = req_arith[g];
        m_exp = shift_ref(m_sh_data, int'(m_sh_amt), m_sh_left, m_sh_arith);
      end else if (m_act && m_resp) begin
        if (flush || rsp_ready) begin m_act = 0; m_resp = 0; end
      end else if (m_act) begin
        if (m_t >= 2 && sh_done) begin
          if (m_drop || flush) begin m_act = 0; m_drop = 0; end
          else begin m_resp = 1; m_rsp_data = m_exp; end
        end else if (flush) begin
          m_drop = 1;
        end
        m_t++;
      end
    end
  end

  logic [NR-1:0]   s_rdy, s_hs;
  logic            s_rv, s_start, s_busy;
  logic [XLEN-1:0] s_rd;
  logic [0:0]      s_id;

  task automatic step();
    @(negedge clk);
    s_rdy = req_ready; s_hs = req_valid & req_ready; s_rv = rsp_valid;
    s_rd = rsp_data; s_id = rsp_id; s_start = sh_start; s_busy = busy;
    @(posedge clk); #1;
  endtask

  task automatic set_op(input int i, input logic [XLEN-1:0] d, input int a,
                        input logic l, input logic ar);
    req_data[i*XLEN +: XLEN] = d;
    req_amount[i*SAW +: SAW] = SAW'(a);
    req_left[i]  = l;
    req_arith[i] = ar;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; flush = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
  endtask

  task automatic run_single(input int i, input logic [XLEN-1:0] d, input int a,
                            input logic l, input logic ar, input int win,
                            output int first, output logic [XLEN-1:0] rd,
                            output int rid, output int smask);
    set_op(i, d, a, l, ar);
    req_valid[i] = 1'b1; rsp_ready = 1'b1;
    first = -1; smask = 0; rd = '0; rid = -1;
    for (int cc = 0; cc < win; cc++) begin
      step();
      if (s_start) smask |= (1 << cc);
      if (s_rv && first < 0) begin first = cc; rd = s_rd; rid = int'(s_id); end
      if (s_hs[i]) req_valid[i] = 1'b0;
    end
  endtask

  int first, rid, smask, g1, gcount;
  logic [XLEN-1:0] rd, d0;
  logic [0:0] id0;
  logic early_rv, found;
  int gq[$];
  int rq[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; req_amount = '0; req_left = '0;
    req_arith = '0; flush = 1'b0; rsp_ready = 1'b1;
    do_reset();
    chk("reset_sh_data", sh_data, 0);
    chk("reset_rsp_id", rsp_id, 0);

    run_single(0, 32'h0000_0001, 5, 1'b1, 1'b0, 10, first, rd, rid, smask);
    chk("left_rsp_cycle", first, 6);
    chk("left_rsp_data", rd, 32'h0000_0020);
    chk("left_rsp_id", rid, 0);
    chk("left_start_mask", smask, 2);

    run_single(1, 32'h8000_0000, 4, 1'b0, 1'b1, 10, first, rd, rid, smask);
    chk("asr_rsp_cycle", first, 6);
    chk("asr_rsp_data", rd, 32'hF800_0000);
    chk("asr_rsp_id", rid, 1);
    run_single(1, 32'h1234_5678, 0, 1'b0, 1'b1, 8, first, rd, rid, smask);
    chk("zero_rsp_cycle", first, 4);
    chk("zero_rsp_data", rd, 32'h1234_5678);

    // Contention: both requesters always valid.
    do_reset();
    set_op(0, $urandom, $urandom_range(0, 7), 1'b1, 1'b0);
    set_op(1, $urandom, $urandom_range(0, 7), 1'b0, 1'b1);
    req_valid = 2'b11; rsp_ready = 1'b1;
    for (int cc = 0; cc < 60; cc++) begin
      step();
      chk("cont_onehot", $countones(s_rdy) <= 1, 1);
      if (s_rdy != '0) gq.push_back(s_rdy[1] ? 1 : 0);
      if (s_rv) rq.push_back(int'(s_id));
      for (int i = 0; i < NR; i++)
        if (s_hs[i]) set_op(i, $urandom, $urandom_range(0, 7), 1'($urandom), 1'($urandom));
    end
    gcount = (gq.size() >= 4 && rq.size() >= 4) ? 1 : 0;
    chk("cont_count", gcount, 1);
    if (gcount == 1)
      for (int k = 0; k < 4; k++) begin
        chk("cont_grant", gq[k], k % 2);
        chk("cont_rsp_id", rq[k], gq[k]);
      end

    // Response backpressure.
    do_reset();
    rsp_ready = 1'b0;
    set_op(0, 32'hF0F0_0001, 3, 1'b0, 1'b0);
    set_op(1, 32'h0000_0003, 1, 1'b1, 1'b0);
    req_valid = 2'b11;
    found = 1'b0;
    for (int cc = 0; cc < 30 && !found; cc++) begin
      step();
      if (s_hs[0]) req_valid[0] = 1'b0;
      if (s_rv) found = 1'b1;
    end
    chk("bp_reach_resp", found, 1);
    d0 = s_rd; id0 = s_id;
    chk("bp_data", d0, 32'h1E1E_0000);
    chk("bp_id", id0, 0);
    for (int cc = 0; cc < 10; cc++) begin
      step();
      chk("bp_hold_valid", s_rv, 1);
      chk("bp_hold_data", s_rd, d0);
      chk("bp_hold_id", s_id, id0);
      chk("bp_no_ready", s_rdy, 0);
    end
    rsp_ready = 1'b1;
    for (int cc = 0; cc < 12; cc++) begin
      step();
      if (s_hs[1]) req_valid[1] = 1'b0;
    end

    // Flush during WAIT of a long op.
    do_reset();
    rsp_ready = 1'b1;
    set_op(0, 32'hDEAD_BEEF, 31, 1'b1, 1'b0);
    set_op(1, 32'h0000_00FF, 0, 1'b0, 1'b0);
    req_valid = 2'b01; g1 = -1; early_rv = 1'b0;
    for (int cc = 0; cc < 25; cc++) begin
      if (cc == 1) req_valid[1] = 1'b1;
      if (cc == 3) flush = 1'b1;
      if (cc == 4) flush = 1'b0;
      step();
      if (s_hs[0]) req_valid[0] = 1'b0;
      if (s_rdy[1] && g1 < 0) g1 = cc;
      if (s_hs[1]) req_valid[1] = 1'b0;
      if (s_rv && (g1 < 0 || cc <= g1)) early_rv = 1'b1;
    end
    chk("flush_wait_grant_cycle", g1, 15);
    chk("flush_wait_no_rsp", early_rv, 0);

    // Flush in RESP together with rsp_ready.
    do_reset();
    rsp_ready = 1'b0;
    set_op(0, 32'h0000_1234, 0, 1'b0, 1'b0);
    req_valid = 2'b01;
    for (int cc = 0; cc < 8; cc++) begin
      if (cc == 4) begin flush = 1'b1; rsp_ready = 1'b1; end
      if (cc == 5) flush = 1'b0;
      step();
      if (s_hs[0]) req_valid[0] = 1'b0;
      if (cc == 4) chk("flush_resp_valid_before", s_rv, 1);
      if (cc == 5) begin
        chk("flush_resp_valid_after", s_rv, 0);
        chk("flush_resp_idle", s_busy, 0);
      end
    end

    // Reset during WAIT.
    do_reset();
    rsp_ready = 1'b1;
    set_op(0, 32'hAAAA_5555, 31, 1'b0, 1'b1);
    req_valid = 2'b01;
    for (int cc = 0; cc < 5; cc++) begin
      step();
      if (s_hs[0]) req_valid[0] = 1'b0;
    end
    chk("mid_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_sh_data", sh_data, 0);
    chk("mid_rst_sh_amount", sh_amount, 0);
    chk("mid_rst_sh_arith", sh_arith, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_req_ready", req_ready, 0);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    set_op(0, 32'h0000_0F00, 4, 1'b1, 1'b0);
    set_op(1, 32'h0000_0001, 1, 1'b1, 1'b0);
    req_valid = 2'b11; first = -1;
    for (int cc = 0; cc < 16; cc++) begin
      step();
      if (cc == 0) chk("mid_first_grant", s_rdy, 2'b01);
      if (s_rv && first < 0) begin
        first = cc;
        chk("mid_first_rsp_data", s_rd, 32'h0000_F000);
        chk("mid_first_rsp_id", s_id, 0);
      end
      for (int i = 0; i < NR; i++) if (s_hs[i]) req_valid[i] = 1'b0;
    end
    chk("mid_first_rsp_cycle", first, 6);

    // Randomized soak against the reference model.
    do_reset();
    for (int cc = 0; cc < 3000; cc++) begin
      for (int i = 0; i < NR; i++)
        if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          set_op(i, $urandom, $urandom_range(0, 31), 1'($urandom), 1'($urandom));
          req_valid[i] = 1'b1;
        end
      flush     = ($urandom_range(0, 15) == 0);
      rsp_ready = ($urandom_range(0, 2) != 0);
      step();
      for (int i = 0; i < NR; i++) if (s_hs[i]) req_valid[i] = 1'b0;
    end
    flush = 1'b0; req_valid = '0; rsp_ready = 1'b1;
    repeat (20) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
